cop_wb_queue: RTL and testbench
===============================

// Module: cop_wb_queue
// PURPOSE
//  Writeback queue downstream of the coprocessor ISE decoder/datapath.
//  Captures each coprocessor result (cop_wr/cop_rd + destination index from cop_insn[11:7]).
//  Drains results into the core register-file write port only in cycles the core is not writing.
//  Drives cop_rdywr back to the ISE, so the ISE stalls (cop_ready=0) only when the queue is full.
//  Reports read-after-write hazards on queued destinations, so the core can stall operand reads.
// PARAMETERS
//  XLEN   32  data width of cop_rd / rf_wdata
//  DEPTH  2   queue entries; power of two, >=2
// PORTS
//  cop_clk      in   1     clock; all state updates on rising edge
//  cop_rst      in   1     reset, synchronous, active-low
//  cop_wr       in   1     ISE result valid this cycle
//  cop_rd       in   XLEN  ISE result data
//  cop_insn     in   32    instruction being executed; [11:7] = destination register index
//  cop_rdywr    out  1     queue can accept a result this cycle
//  core_wb_busy in   1     core owns the RF write port this cycle (core has priority)
//  rf_we        out  1     RF write enable for a queued coprocessor result
//  rf_waddr     out  5     RF write index
//  rf_wdata     out  XLEN  RF write data
//  rs1_idx      in   5     source index read by the core in decode
//  rs2_idx      in   5     source index read by the core in decode
//  hazard       out  1     rs1_idx/rs2_idx (nonzero) matches a pending destination
//  pend_cnt     out  $clog2(DEPTH+1)  number of occupied entries
// BEHAVIOUR
//  Reset (cop_rst==0 at edge):
//   - count=0; rd/wr pointers=0; entries discarded, including mid-drain.
//   - Next cycle: rf_we=0, hazard=0, pend_cnt=0, cop_rdywr=1; rf_waddr/rf_wdata=0.
//  cop_rdywr = (count < DEPTH):
//   - Depends on registered state only; no combinational path from core_wb_busy.
//  Enqueue:
//   - Fires when cop_wr && cop_rdywr; entry {cop_insn[11:7], cop_rd} written at the tail.
//   - Destination x0: accepted (handshake completes) but not stored.
//   - cop_wr && !cop_rdywr: legal stall; nothing stored; the ISE holds the same result.
//  Dequeue:
//   - rf_we = (count!=0) && !core_wb_busy.
//   - rf_waddr/rf_wdata = head entry, driven combinationally from the head register.
//   - Head pops at the edge where rf_we=1.
//  Latency: enqueued at edge N -> earliest rf_we in cycle N+1. No bypass from cop_rd to rf_*.
//  Simultaneous enqueue+dequeue: count unchanged; both pointers advance, wrapping mod DEPTH.
//   - When full, no enqueue is possible that cycle, even if a dequeue occurs (cop_rdywr is already 0).
//  Ordering: strict FIFO, so two writes to the same rd retire in program order.
//  hazard:
//   - Asserted when any valid entry, or the current cop_wr with rd!=0, has a destination equal to a nonzero rs1_idx or rs2_idx.
//   - Combinational.
//   - Entry popping this cycle still counts; the RF write lands at the edge.
//  Empty + core_wb_busy: no action. Full + core_wb_busy held: queue stays full indefinitely; no loss.
//  pend_cnt = count (registered).
// STRUCTURE
//  Shared package cop_pkg:
//   - XLEN, REG_IDX_W=5, RD_LSB=7.
//   - CUSTOM_0..3 opcode constants.
//   - Typedef cop_wb_t {logic [4:0] idx; logic [XLEN-1:0] data;}.
//  Sub-module cop_fifo:
//   - Generic synchronous FIFO with push/pop/full/empty/count and head view, plus a per-entry valid/index vector for hazard compare.
//  Top contains:
//   - x0 filter.
//   - Arbitration against core_wb_busy.
//   - Hazard comparators.
// TESTING
//  1. Reset then cop_wr=1, insn[11:7]=5, cop_rd=0xDEADBEEF, core_wb_busy=0
//     -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, pend_cnt=1, then 0.
//  2. core_wb_busy=1 held; three back-to-back results to x1,x2,x3
//     -> cop_rdywr=0 after two, third held by ISE;
//     -> on release: writes x1,x2,x3 in consecutive cycles.
//  3. Result to x0 -> cop_rdywr stays 1, pend_cnt=0, rf_we never asserted.
//  4. Queue holds x7, rs1_idx=7 -> hazard=1; rs1_idx=0 with x0 never stored -> hazard=0;
//     hazard clears the cycle after x7 retires.
//  5. Full queue, drop cop_rst low for one edge -> pend_cnt=0, rf_we=0, cop_rdywr=1; stale data never written.
//  6. Two results to x9 (0x1 then 0x2), busy toggling -> final RF x9 = 0x2; simultaneous enq/deq keeps pend_cnt constant.

Source files
------------

// File: rtl/cop_pkg.sv
// Shared definitions for the coprocessor writeback path: widths, the custom
// opcode space, and the queued-result record.
package cop_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int RD_LSB    = 7;

  localparam logic [6:0] CUSTOM_0 = 7'b0001011;
  localparam logic [6:0] CUSTOM_1 = 7'b0101011;
  localparam logic [6:0] CUSTOM_2 = 7'b1011011;
  localparam logic [6:0] CUSTOM_3 = 7'b1111011;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      data;
  } cop_wb_t;

  // x0 is never a real dependency, so a zero source index never matches.
  function automatic logic idx_match(input logic [REG_IDX_W-1:0] dst,
                                     input logic [REG_IDX_W-1:0] src1,
                                     input logic [REG_IDX_W-1:0] src2);
    idx_match = ((src1 != '0) && (src1 == dst)) ||
                ((src2 != '0) && (src2 == dst));
  endfunction

endpackage

// File: rtl/cop_fifo.sv
// Generic synchronous FIFO with head view and a per-entry valid/key view,
// so the owner can compare against everything still in flight.
module cop_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2,
  parameter int KEY_W = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [CNT_W-1:0]       count_o,
  output logic [WIDTH-1:0]       head_o,
  output logic [DEPTH-1:0]       valid_o,
  output logic [DEPTH*KEY_W-1:0] key_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = valid_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_key
    assign key_o[g*KEY_W +: KEY_W] = mem_q[g][WIDTH-1 -: KEY_W];
  end

  // A push can only land on a free slot, so it never collides with the pop slot.
  always_comb begin
    valid_d = valid_q;
    if (pop_ok)  valid_d[rd_ptr_q] = 1'b0;
    if (push_ok) valid_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/cop_wb_queue.sv
// Coprocessor writeback queue: buffers results and retires them into the core
// register file in cycles the core leaves the write port idle.
module cop_wb_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                         cop_clk,
  input  logic                         cop_rst,
  input  logic                         cop_wr,
  input  logic [XLEN-1:0]              cop_rd,
  input  logic [31:0]                  cop_insn,
  output logic                         cop_rdywr,
  input  logic                         core_wb_busy,
  output logic                         rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [XLEN-1:0]              rf_wdata,
  input  logic [4:0]                   rs1_idx,
  input  logic [4:0]                   rs2_idx,
  output logic                         hazard,
  output logic [$clog2(DEPTH+1)-1:0]   pend_cnt
);

  import cop_pkg::*;

  localparam int ENT_W = REG_IDX_W + XLEN;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [REG_IDX_W-1:0]       dst_idx;
  logic                       push, pop, full, empty;
  logic [ENT_W-1:0]           head;
  logic [DEPTH-1:0]           ent_valid;
  logic [DEPTH*REG_IDX_W-1:0] ent_key;
  logic [CNT_W-1:0]           count;
  logic                       unused_insn;

  assign dst_idx     = cop_insn[RD_LSB +: REG_IDX_W];
  assign unused_insn = ^{cop_insn[31:RD_LSB+REG_IDX_W], cop_insn[RD_LSB-1:0]};

  // Ready is a function of occupancy only; the ISE never waits on core_wb_busy.
  assign cop_rdywr = !full;
  // A result for x0 completes the handshake but is dropped here.
  assign push      = cop_wr && cop_rdywr && (dst_idx != '0);
  assign pop       = rf_we;

  assign rf_we     = !empty && !core_wb_busy;
  assign rf_waddr  = head[ENT_W-1 -: REG_IDX_W];
  assign rf_wdata  = head[XLEN-1:0];
  assign pend_cnt  = count;

  cop_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH),
    .KEY_W (REG_IDX_W)
  ) u_fifo (
    .clk_i   (cop_clk),
    .rst_ni  (cop_rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({dst_idx, cop_rd}),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head),
    .valid_o (ent_valid),
    .key_o   (ent_key)
  );

  // The popping entry still counts: its RF write only lands at the edge.
  always_comb begin
    hazard = 1'b0;
    if (cop_wr && (dst_idx != '0) && idx_match(dst_idx, rs1_idx, rs2_idx))
      hazard = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && idx_match(ent_key[i*REG_IDX_W +: REG_IDX_W], rs1_idx, rs2_idx))
        hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_cop_wb_queue.sv
// Directed bench for cop_wb_queue with a scoreboard of expected RF writes.
module tb_cop_wb_queue;

  logic        cop_clk = 1'b0;
  logic        cop_rst;
  logic        cop_wr;
  logic [31:0] cop_rd;
  logic [31:0] cop_insn;
  logic        cop_rdywr;
  logic        core_wb_busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rs1_idx, rs2_idx;
  logic        hazard;
  logic [1:0]  pend_cnt;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rf_model [32];
  int          tests = 0;
  int          fails = 0;

  always #5 cop_clk = ~cop_clk;

  cop_wb_queue #(.XLEN(32), .DEPTH(2)) dut (
    .cop_clk      (cop_clk),
    .cop_rst      (cop_rst),
    .cop_wr       (cop_wr),
    .cop_rd       (cop_rd),
    .cop_insn     (cop_insn),
    .cop_rdywr    (cop_rdywr),
    .core_wb_busy (core_wb_busy),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rs1_idx      (rs1_idx),
    .rs2_idx      (rs2_idx),
    .hazard       (hazard),
    .pend_cnt     (pend_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] insn(input logic [4:0] rd);
    insn = {20'h00ABC, rd, 7'b0001011};
  endfunction

  task automatic step();
    @(posedge cop_clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] idx, input logic [31:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    sb.push_back(e);
  endtask

  // Every retired write must match the oldest expected result.
  always @(negedge cop_clk) begin
    if (cop_rst === 1'b1 && rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {59'd0, rf_waddr}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_addr", rf_waddr, e.idx);
        chk("wb_data", rf_wdata, e.data);
      end
      rf_model[rf_waddr] = rf_wdata;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    cop_rst = 1'b0; cop_wr = 1'b0; cop_rd = '0; cop_insn = '0;
    core_wb_busy = 1'b0; rs1_idx = '0; rs2_idx = '0;
    step(); step();
    cop_rst = 1'b1;
    @(negedge cop_clk);
    chk("rst_rdywr", cop_rdywr, 1);
    chk("rst_we", rf_we, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_cnt", pend_cnt, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);

    // single result, no bypass, retires next cycle
    step();
    cop_wr = 1'b1; cop_insn = insn(5); cop_rd = 32'hDEADBEEF;
    push_exp(5, 32'hDEADBEEF);
    @(negedge cop_clk);
    chk("t1_nobypass", rf_we, 0);
    chk("t1_rdy", cop_rdywr, 1);
    step();
    cop_wr = 1'b0;
    @(negedge cop_clk);
    chk("t1_we", rf_we, 1);
    chk("t1_cnt1", pend_cnt, 1);
    step();
    @(negedge cop_clk);
    chk("t1_cnt0", pend_cnt, 0);
    chk("t1_we0", rf_we, 0);

    // fill under core_wb_busy, third result held by the ISE
    step();
    core_wb_busy = 1'b1;
    cop_wr = 1'b1; cop_insn = insn(1); cop_rd = 32'h11; push_exp(1, 32'h11);
    step();
    cop_insn = insn(2); cop_rd = 32'h22; push_exp(2, 32'h22);
    step();
    cop_insn = insn(3); cop_rd = 32'h33; push_exp(3, 32'h33);
    @(negedge cop_clk);
    chk("t2_full_rdy", cop_rdywr, 0);
    chk("t2_full_cnt", pend_cnt, 2);
    step(); step(); step();
    @(negedge cop_clk);
    chk("t2_hold_cnt", pend_cnt, 2);
    chk("t2_hold_we", rf_we, 0);
    step();
    core_wb_busy = 1'b0;
    @(negedge cop_clk);
    chk("t2_w1", rf_we, 1);
    chk("t2_w1_rdy", cop_rdywr, 0);
    step();
    @(negedge cop_clk);
    chk("t2_w2", rf_we, 1);
    chk("t2_w2_rdy", cop_rdywr, 1);
    step();
    cop_wr = 1'b0;
    @(negedge cop_clk);
    chk("t2_w3", rf_we, 1);
    chk("t2_w3_cnt", pend_cnt, 1);
    step();
    @(negedge cop_clk);
    chk("t2_empty", pend_cnt, 0);

    // x0 result: accepted, never stored
    step();
    cop_wr = 1'b1; cop_insn = insn(0); cop_rd = 32'h99;
    @(negedge cop_clk);
    chk("t3_rdy", cop_rdywr, 1);
    step();
    cop_wr = 1'b0;
    @(negedge cop_clk);
    chk("t3_cnt", pend_cnt, 0);
    chk("t3_we", rf_we, 0);
    step();
    @(negedge cop_clk);
    chk("t3_we_later", rf_we, 0);

    // hazards
    step();
    core_wb_busy = 1'b1;
    cop_wr = 1'b1; cop_insn = insn(7); cop_rd = 32'h77; push_exp(7, 32'h77);
    step();
    cop_wr = 1'b0; rs1_idx = 5'd7;
    @(negedge cop_clk);
    chk("t4_haz_q", hazard, 1);
    step();
    rs1_idx = 5'd0; cop_wr = 1'b1; cop_insn = insn(0); cop_rd = 32'h55;
    @(negedge cop_clk);
    chk("t4_haz_x0", hazard, 0);
    step();
    cop_wr = 1'b0; rs1_idx = 5'd7; core_wb_busy = 1'b0;
    @(negedge cop_clk);
    chk("t4_pop_we", rf_we, 1);
    chk("t4_haz_pop", hazard, 1);
    step();
    @(negedge cop_clk);
    chk("t4_haz_clr", hazard, 0);
    chk("t4_cnt", pend_cnt, 0);
    step();
    rs1_idx = 5'd0; rs2_idx = 5'd12;
    cop_wr = 1'b1; cop_insn = insn(12); cop_rd = 32'hC; push_exp(12, 32'hC);
    @(negedge cop_clk);
    chk("t4_haz_cur", hazard, 1);
    step();
    cop_wr = 1'b0; rs2_idx = 5'd0;
    @(negedge cop_clk);
    chk("t4_haz_none", hazard, 0);
    step();

    // reset while full: stale entries must never reach the RF
    step();
    core_wb_busy = 1'b1;
    cop_wr = 1'b1; cop_insn = insn(20); cop_rd = 32'hA0;
    step();
    cop_insn = insn(21); cop_rd = 32'hA1;
    step();
    cop_wr = 1'b0;
    @(negedge cop_clk);
    chk("t5_full_cnt", pend_cnt, 2);
    chk("t5_full_rdy", cop_rdywr, 0);
    step();
    cop_rst = 1'b0;
    step();
    cop_rst = 1'b1; core_wb_busy = 1'b0; rs1_idx = 5'd20;
    @(negedge cop_clk);
    chk("t5_cnt", pend_cnt, 0);
    chk("t5_we", rf_we, 0);
    chk("t5_rdy", cop_rdywr, 1);
    chk("t5_haz", hazard, 0);
    chk("t5_waddr", rf_waddr, 0);
    chk("t5_wdata", rf_wdata, 0);
    rs1_idx = 5'd0;
    step(); step(); step();
    @(negedge cop_clk);
    chk("t5_we_later", rf_we, 0);

    // two writes to x9 with busy toggling
    step();
    core_wb_busy = 1'b1;
    cop_wr = 1'b1; cop_insn = insn(9); cop_rd = 32'h1; push_exp(9, 32'h1);
    step();
    cop_rd = 32'h2; core_wb_busy = 1'b0; push_exp(9, 32'h2);
    @(negedge cop_clk);
    chk("t6_cnt_a", pend_cnt, 1);
    chk("t6_we_a", rf_we, 1);
    step();
    cop_wr = 1'b0; core_wb_busy = 1'b1;
    @(negedge cop_clk);
    chk("t6_cnt_b", pend_cnt, 1);
    chk("t6_we_b", rf_we, 0);
    step();
    core_wb_busy = 1'b0;
    @(negedge cop_clk);
    chk("t6_we_c", rf_we, 1);
    step();
    @(negedge cop_clk);
    chk("t6_cnt_end", pend_cnt, 0);
    chk("t6_x9", rf_model[9], 32'h2);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
